// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the program loader.
// Optional checksum byte enabled by defining PROG_LOADER_CHK_EN.
package prog_loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    GET_PC,
    GET_CNT,
    GET_HI,
    GET_LO,
    WRITE,
    CHK,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         ADDR_W_DEFAULT = 8;

  // States in which the loader takes a byte from the host link.
  function automatic logic accepts_byte(state_t s);
    return (s != WRITE) && (s != DONE);
  endfunction

endpackage

// File: rtl/prog_loader_chk.sv
// Running XOR checksum over the frame payload bytes.
// Instantiated by prog_loader only when PROG_LOADER_CHK_EN is defined.
module prog_loader_chk (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] data,
  output logic [7:0] sum
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum <= 8'h00;
    end else if (clear) begin
      sum <= 8'h00;
    end else if (enable) begin
      sum <= sum ^ data;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader: writes 16-bit words into program RAM, then starts the CPU.
// Define PROG_LOADER_CHK_EN to require a trailing XOR checksum byte per frame.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [7:0] HEADER = HEADER_DEFAULT,
  parameter int         ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [15:0]       ram_w_data,
  output logic              start,
  output logic [ADDR_W-1:0] start_pc,
  output logic              busy,
  output logic              err
);

  state_t            state_reg;
  logic              run_reg;
  logic [7:0]        count_reg;
  logic [7:0]        hi_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] w_addr_reg;
  logic [15:0]       w_data_reg;
  logic [ADDR_W-1:0] start_pc_reg;
  logic              xfer;

  // run_reg keeps byte_ready low while reset is asserted, even though IDLE accepts bytes.
  assign byte_ready = run_reg & accepts_byte(state_reg);
  assign xfer       = byte_valid & byte_ready;
  assign ram_w_en   = (state_reg == WRITE);
  assign start      = (state_reg == DONE);
  assign busy       = !(state_reg inside {IDLE, ERR});
  assign ram_w_addr = w_addr_reg;
  assign ram_w_data = w_data_reg;
  assign start_pc   = start_pc_reg;

`ifdef PROG_LOADER_CHK_EN
  logic [7:0] chk_sum;
  logic       chk_clear;
  logic       chk_en;
  logic       err_reg;

  assign chk_clear = xfer && (byte_data == HEADER) && (state_reg inside {IDLE, ERR});
  assign chk_en    = xfer && (state_reg inside {GET_PC, GET_CNT, GET_HI, GET_LO});
  assign err       = err_reg;

  prog_loader_chk u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (chk_clear),
    .enable (chk_en),
    .data   (byte_data),
    .sum    (chk_sum)
  );

  localparam state_t AFTER_LAST = CHK;
`else
  assign err = 1'b0;

  localparam state_t AFTER_LAST = DONE;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      run_reg      <= 1'b0;
      count_reg    <= 8'h00;
      hi_reg       <= 8'h00;
      addr_reg     <= '0;
      w_addr_reg   <= '0;
      w_data_reg   <= 16'h0000;
      start_pc_reg <= '0;
`ifdef PROG_LOADER_CHK_EN
      err_reg      <= 1'b0;
`endif
    end else begin
      run_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (xfer && byte_data == HEADER) state_reg <= GET_PC;
        end
        GET_PC: begin
          if (xfer) begin
            start_pc_reg <= ADDR_W'(byte_data);
            addr_reg     <= ADDR_W'(byte_data);
            state_reg    <= GET_CNT;
          end
        end
        GET_CNT: begin
          if (xfer) begin
            count_reg <= byte_data;
            state_reg <= (byte_data == 8'h00) ? AFTER_LAST : GET_HI;
          end
        end
        GET_HI: begin
          if (xfer) begin
            hi_reg    <= byte_data;
            state_reg <= GET_LO;
          end
        end
        GET_LO: begin
          // Write port registers change only here, so they hold between strobes.
          if (xfer) begin
            w_addr_reg <= addr_reg;
            w_data_reg <= {hi_reg, byte_data};
            state_reg  <= WRITE;
          end
        end
        WRITE: begin
          addr_reg  <= addr_reg + 1'b1;
          count_reg <= count_reg - 8'h01;
          state_reg <= (count_reg == 8'h01) ? AFTER_LAST : GET_HI;
        end
`ifdef PROG_LOADER_CHK_EN
        CHK: begin
          if (xfer) begin
            if (byte_data == chk_sum) begin
              state_reg <= DONE;
            end else begin
              state_reg <= ERR;
              err_reg   <= 1'b1;
            end
          end
        end
`endif
        DONE: begin
          state_reg <= IDLE;
`ifdef PROG_LOADER_CHK_EN
          err_reg   <= 1'b0;
`endif
        end
        ERR: begin
          if (xfer && byte_data == HEADER) begin
            state_reg <= GET_PC;
`ifdef PROG_LOADER_CHK_EN
            err_reg   <= 1'b0;
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of frames plus hand-written corner sequences.
// Expected RAM writes and start pulses are queued on drive and popped by an output monitor.
module tb_prog_loader;

`ifdef PROG_LOADER_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        ram_w_en;
  logic [7:0]  ram_w_addr;
  logic [15:0] ram_w_data;
  logic        start;
  logic [7:0]  start_pc;
  logic        busy;
  logic        err;

  prog_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .ram_w_en   (ram_w_en),
    .ram_w_addr (ram_w_addr),
    .ram_w_data (ram_w_data),
    .start      (start),
    .start_pc   (start_pc),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct packed {
    logic [1:0]  n_pre;
    logic [15:0] pre;
    logic [7:0]  pc;
    logic [1:0]  n_words;
    logic [47:0] words;
    logic        gaps;
    logic        bad;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  wr_t         exp_wr_q[$];
  logic [7:0]  exp_start_q[$];
  logic [15:0] frame_words[$];
  vec_t        vecs[7];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  // Output monitor: every write strobe and start pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (ram_w_en || start) check("start_and_wen_exclusive", {30'd0, start, ram_w_en} == 32'd3, 0);
    if (ram_w_en) begin
      check("ready_low_in_write", byte_ready, 1'b0);
      if (exp_wr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=0x%0h@0x%0h required=none", ram_w_data, ram_w_addr);
      end else begin
        wr_t e;
        e = exp_wr_q.pop_front();
        check("write_addr", ram_w_addr, e.addr);
        check("write_data", ram_w_data, e.data);
        $display("write 0x%04h @ 0x%02h (expected 0x%04h @ 0x%02h)", ram_w_data, ram_w_addr, e.data, e.addr);
      end
    end
    if (start) begin
      if (exp_start_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_start actual=pc 0x%0h required=none", start_pc);
      end else begin
        logic [7:0] p;
        p = exp_start_q.pop_front();
        check("start_pc_at_start", start_pc, p);
        $display("start pc=0x%02h (expected 0x%02h)", start_pc, p);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic gap);
    int   waited = 0;
    logic rdy;
    byte_valid = 1'b1;
    byte_data  = b;
    forever begin
      @(negedge clk);
      rdy = byte_ready;
      @(posedge clk);
      if (rdy) break;
      waited++;
      if (waited > 40) begin
        checks++;
        failures++;
        $display("FAIL byte_accept_timeout actual=not_ready required=ready byte=0x%0h", b);
        break;
      end
    end
    #1;
    byte_valid = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] frame_sum(input logic [7:0] pc);
    logic [7:0] s;
    s = pc ^ 8'(frame_words.size());
    foreach (frame_words[k]) s = s ^ frame_words[k][15:8] ^ frame_words[k][7:0];
    return s;
  endfunction

  task automatic send_frame(input logic [7:0] pc, input logic gaps, input logic bad);
    logic [7:0] cnt;
    logic [7:0] sum;
    cnt = 8'(frame_words.size());
    sum = frame_sum(pc);
    foreach (frame_words[k]) exp_wr_q.push_back({pc + 8'(k), frame_words[k]});
    if (!(bad && CHK_EN)) exp_start_q.push_back(pc);
    send_byte(8'hA5, gaps);
    send_byte(pc, gaps);
    send_byte(cnt, gaps);
    foreach (frame_words[k]) begin
      send_byte(frame_words[k][15:8], gaps);
      send_byte(frame_words[k][7:0], gaps);
    end
`ifdef PROG_LOADER_CHK_EN
    send_byte(bad ? ~sum : sum, gaps);
`endif
  endtask

  task automatic drain(input string tag);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_writes_pending"}, exp_wr_q.size(), 0);
    check({tag, "_starts_pending"}, exp_start_q.size(), 0);
    exp_wr_q.delete();
    exp_start_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{2'd0, 16'h0000, 8'h10, 2'd2, 48'h1234_ABCD_0000, 1'b0, 1'b0};
    vecs[1] = '{2'd2, 16'h00FF, 8'h20, 2'd0, 48'h0,              1'b0, 1'b0};
    vecs[2] = '{2'd0, 16'h0000, 8'hFF, 2'd2, 48'h1111_2222_0000, 1'b0, 1'b0};
    vecs[3] = '{2'd0, 16'h0000, 8'h10, 2'd2, 48'h1234_ABCD_0000, 1'b1, 1'b0};
    vecs[4] = '{2'd0, 16'h0000, 8'hA5, 2'd3, 48'hA5A5_00FF_5A5A, 1'b0, 1'b0};
    vecs[5] = '{2'd0, 16'h0000, 8'h40, 2'd1, 48'hBEEF_0000_0000, 1'b0, 1'b1};
    vecs[6] = '{2'd2, 16'h3300, 8'h50, 2'd1, 48'h1357_0000_0000, 1'b1, 1'b0};

    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_byte_ready", byte_ready, 1'b0);
    check("rst_ram_w_en", ram_w_en, 1'b0);
    check("rst_ram_w_addr", ram_w_addr, 8'h00);
    check("rst_ram_w_data", ram_w_data, 16'h0000);
    check("rst_start", start, 1'b0);
    check("rst_start_pc", start_pc, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ready", byte_ready, 1'b1);

    for (int v = 0; v < 7; v++) begin
      for (int p = 0; p < int'(vecs[v].n_pre); p++) send_byte(vecs[v].pre[15-8*p -: 8], vecs[v].gaps);
      frame_words.delete();
      for (int w = 0; w < int'(vecs[v].n_words); w++) frame_words.push_back(vecs[v].words[47-16*w -: 16]);
      send_frame(vecs[v].pc, vecs[v].gaps, vecs[v].bad);
      drain($sformatf("vec%0d", v));
      check($sformatf("vec%0d_start_pc", v), start_pc, vecs[v].pc);
      check($sformatf("vec%0d_busy", v), busy, 1'b0);
      check($sformatf("vec%0d_err", v), err, vecs[v].bad && CHK_EN);
      $display("vector %0d pc=0x%02h words=%0d gaps=%0d bad=%0d done", v, vecs[v].pc, vecs[v].n_words, vecs[v].gaps, vecs[v].bad);
    end

    // Latency: write strobe the cycle after the last LO byte, start one cycle later without checksum.
    frame_words.delete();
    frame_words.push_back(16'h7788);
    exp_wr_q.push_back({8'h30, 16'h7788});
    exp_start_q.push_back(8'h30);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h30, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    check("lat_w_en", ram_w_en, 1'b1);
    check("lat_ready_in_write", byte_ready, 1'b0);
    check("lat_busy", busy, 1'b1);
    @(posedge clk);
    #1;
    check("lat_start", start, !CHK_EN);
    check("lat_w_en_drop", ram_w_en, 1'b0);
    check("lat_addr_hold", ram_w_addr, 8'h30);
`ifdef PROG_LOADER_CHK_EN
    send_byte(frame_sum(8'h30), 1'b0);
    check("lat_start_after_chk", start, 1'b1);
`endif
    drain("latency");

    // Reset after the HI byte of word 2: the partial frame is abandoned.
    exp_wr_q.push_back({8'h10, 16'h1234});
    send_byte(8'hA5, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_byte_ready", byte_ready, 1'b0);
    check("midrst_ram_w_en", ram_w_en, 1'b0);
    check("midrst_ram_w_addr", ram_w_addr, 8'h00);
    check("midrst_ram_w_data", ram_w_data, 16'h0000);
    check("midrst_start", start, 1'b0);
    check("midrst_start_pc", start_pc, 8'h00);
    check("midrst_busy", busy, 1'b0);
    rst_n = 1'b1;
    drain("midrst");
    frame_words.delete();
    frame_words.push_back(16'hCAFE);
    frame_words.push_back(16'hF00D);
    send_frame(8'h60, 1'b0, 1'b0);
    drain("post_rst");
    check("post_rst_start_pc", start_pc, 8'h60);

    // Full 255-word frame wrapping the address past 0xFF.
    frame_words.delete();
    for (int i = 0; i < 255; i++) frame_words.push_back({8'(i), ~8'(i)});
    send_frame(8'hF0, 1'b0, 1'b0);
    drain("cnt255");
    check("cnt255_start_pc", start_pc, 8'hF0);
    check("cnt255_last_addr", ram_w_addr, 8'hEE);
    check("cnt255_last_data", ram_w_data, 16'hFE01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
